if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS CPU: PC register, next-PC selection and IF/ID pipeline register.
- Drives the instruction-memory bus with a req/ack handshake.
- Presents the fetched word to the ID stage, where the control unit decodes it.
- Consumes the control unit's pcsource[1:0] and the register-file rs value to redirect fetch for beq/bne/j/jal/jr.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 16, max cycles a request may wait for imem_ack before fetch_err

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
imem_req  output  1  fetch request, held until ack
imem_addr  output  32  word address of request (byte address, [1:0]=00)
imem_rdata  input  32  instruction word, valid when imem_ack=1
imem_ack  input  1  one-cycle completion strobe; may assert in the same cycle as imem_req
stall  input  1  ID stage cannot accept; hold IF/ID contents
pcsource  input  2  from control unit: 00 pc+4, 01 jr, 10 branch taken, 11 j/jal
rs_data  input  32  jr target from register file
if_id_instr  output  32  instruction for ID stage
if_id_pc4  output  32  address of if_id_instr + 4
if_id_valid  output  1  if_id_instr is a real instruction, not a bubble
fetch_misalign  output  1  one-cycle pulse: jr target had [1:0]!=00
fetch_err  output  1  sticky bus-timeout flag, cleared only by rst

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high (rst sampled on clk rising edge).
- Reset values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, fetch_misalign=0, fetch_err=0, FSM=IDLE. rst mid-transaction abandons any outstanding request; a late ack is ignored.
- FSM states: IDLE, REQ, SKID, DRAIN, ERR.
- IDLE: imem_req=0. Always moves to REQ the next cycle.
- REQ:
  - imem_req=1, imem_addr=pc, both stable until ack.
  - On ack with no stall and no redirect: if_id_instr<=imem_rdata, if_id_pc4<=pc+4, if_id_valid<=1, pc<=pc+4. Stay in REQ with a new address.
  - Zero-wait ack gives 1 instruction/cycle.
- SKID:
  - Entered when ack arrives while stall=1; the word and its pc4 are held in a one-entry skid buffer and imem_req=0.
  - When stall falls, the skid buffer moves into IF/ID and the FSM returns to REQ the same cycle.
- Redirect: taken when if_id_valid=1, stall=0 and pcsource!=00. Target:
  - 01: {rs_data[31:2],2'b00}; fetch_misalign pulses if rs_data[1:0]!=00.
  - 10: if_id_pc4 + (sign_extend(if_id_instr[15:0])<<2), modulo 2^32.
  - 11: {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}.
- On redirect: pc<=target and if_id_valid<=0 (bubble).
  - Word acked the same cycle, or held in SKID: discarded.
  - Request outstanding without ack: go to DRAIN, keep req/addr stable until ack, discard the word, then REQ at target.
  - No branch delay slot (default build).
- Stall has priority over redirect; pcsource is re-evaluated each cycle stall is low.
- pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
- Timeout counter: cleared on each ack or new request; counts cycles req=1 without ack. At TIMEOUT_CYCLES go to ERR: imem_req=0, fetch_err=1, if_id_valid=0. Exit only by rst.
- stall=1 with if_id_valid=0 holds the bubble; no instruction is lost.

Optional Feature:
IF_DELAY_SLOT_EN
- Defined: MIPS delay slot. The instruction sequentially after a branch/jump is not squashed.
  - Redirect waits until that instruction is in IF/ID, or is fetched and passed downstream.
  - Target is computed from the branch's pc4 captured at redirect time.
- Undefined: squash behaviour as above.

Decomposition:
- Package cpu_defs_pkg:
  - PCSRC_SEQ=2'b00, PCSRC_JR=2'b01, PCSRC_BR=2'b10, PCSRC_J=2'b11
  - fetch FSM state enum
  - NOP word 32'h0000_0000
- Sub-module npc_calc: combinational target computation from pcsource, if_id_pc4, if_id_instr, rs_data; outputs target and misalign.

Test Plan:
- Reset, zero-wait ack, mem[k]=k: imem_addr 0,4,8,12 on consecutive cycles; if_id_instr 0,1,2 one cycle later; if_id_pc4 4,8,12.
- ack 3 cycles after req, stall=1 during ack: SKID holds word; stall released -> word in IF/ID next cycle; no duplicates or drops.
- beq at 0x100, imm16=16'hFFFC, pcsource=10: next imem_addr 0x0F4; one bubble (if_id_valid=0); fetched 0x104 word discarded.
- jr with rs_data=0x0000_2003, pcsource=01: imem_addr 0x2000; fetch_misalign one-cycle pulse.
- No ack for 16 cycles: fetch_err=1, imem_req=0; rst -> pc=RESET_PC, fetch resumes.
- IF_DELAY_SLOT_EN defined, j at 0x40 target 0x400: 0x44 delivered valid, then 0x400.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared fetch-stage types, pcsource codes and helpers
package cpu_defs_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_JR  = 2'b01;
    localparam logic [1:0] PCSRC_BR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_REQ,
        FS_SKID,
        FS_DRAIN,
        FS_ERR
    } fetch_state_e;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// rtl/npc_calc.sv - redirect target computation for jr, branch and j/jal
module npc_calc
    import cpu_defs_pkg::*;
(
    input  logic [1:0]  pcsource_i,
    input  logic [31:0] pc4_i,
    input  logic [25:0] instr_idx_i,
    input  logic [31:0] rs_data_i,
    output logic [31:0] target_o,
    output logic        misalign_o
);

    always_comb begin
        target_o   = pc4_i;
        misalign_o = 1'b0;
        case (pcsource_i)
            PCSRC_JR: begin
                target_o   = {rs_data_i[31:2], 2'b00};
                misalign_o = |rs_data_i[1:0];
            end
            PCSRC_BR: target_o = pc4_i + branch_offset(instr_idx_i[15:0]);
            PCSRC_J:  target_o = {pc4_i[31:28], instr_idx_i, 2'b00};
            default:  target_o = pc4_i;
        endcase
    end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - PC, next-PC select and IF/ID register; IF_DELAY_SLOT_EN keeps the delay slot
module if_fetch_stage
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] rs_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fetch_misalign,
    output logic        fetch_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, drain_addr_q, drain_addr_d;
    logic [31:0]  instr_q, instr_d, pc4_q, pc4_d;
    logic [31:0]  skid_instr_q, skid_instr_d, skid_pc4_q, skid_pc4_d;
    logic         valid_q, valid_d, misalign_q, misalign_d, err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]  target, pc_plus4, seq_pc;
    logic         tgt_misalign, redirect;
`ifdef IF_DELAY_SLOT_EN
    logic         pend_q, pend_d;
    logic [31:0]  pend_tgt_q, pend_tgt_d;
`endif

    npc_calc u_npc_calc (
        .pcsource_i  (pcsource),
        .pc4_i       (pc4_q),
        .instr_idx_i (instr_q[25:0]),
        .rs_data_i   (rs_data),
        .target_o    (target),
        .misalign_o  (tgt_misalign)
    );

    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = valid_q && !stall && (pcsource != PCSRC_SEQ);
`ifdef IF_DELAY_SLOT_EN
    assign seq_pc = pend_q ? pend_tgt_q : pc_plus4;
`else
    assign seq_pc = pc_plus4;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        misalign_d   = redirect && tgt_misalign;
        imem_req     = 1'b0;
        imem_addr    = pc_q;
`ifdef IF_DELAY_SLOT_EN
        pend_d       = pend_q;
        pend_tgt_d   = pend_tgt_q;
`endif
        case (state_q)
            FS_IDLE: begin
                state_d = FS_REQ;
                cnt_d   = '0;
            end
            FS_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    cnt_d = '0;
                    if (stall) begin
                        state_d      = FS_SKID;
                        skid_instr_d = imem_rdata;
                        skid_pc4_d   = pc_plus4;
                        pc_d         = seq_pc;
`ifdef IF_DELAY_SLOT_EN
                        pend_d       = 1'b0;
`endif
                    end else begin
`ifdef IF_DELAY_SLOT_EN
                        // This word is the delay slot of any branch now in IF/ID.
                        instr_d = imem_rdata;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = redirect ? target : seq_pc;
                        pend_d  = 1'b0;
`else
                        if (redirect) begin
                            pc_d    = target;
                            valid_d = 1'b0;
                        end else begin
                            instr_d = imem_rdata;
                            pc4_d   = pc_plus4;
                            valid_d = 1'b1;
                            pc_d    = pc_plus4;
                        end
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (redirect) begin
                        valid_d = 1'b0;
`ifdef IF_DELAY_SLOT_EN
                        pend_d     = 1'b1;
                        pend_tgt_d = target;
`else
                        pc_d         = target;
                        drain_addr_d = pc_q;
                        state_d      = FS_DRAIN;
`endif
                    end else if (!stall) begin
                        valid_d = 1'b0;
                    end
                end
            end
            FS_SKID: begin
                if (!stall) begin
                    state_d = FS_REQ;
                    cnt_d   = '0;
`ifdef IF_DELAY_SLOT_EN
                    instr_d = skid_instr_q;
                    pc4_d   = skid_pc4_q;
                    valid_d = 1'b1;
                    if (redirect) pc_d = target;
`else
                    if (redirect) begin
                        pc_d    = target;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = skid_instr_q;
                        pc4_d   = skid_pc4_q;
                        valid_d = 1'b1;
                    end
`endif
                end
            end
            FS_DRAIN: begin
                // Old request must complete on the bus; its word is thrown away.
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
                if (imem_ack) begin
                    state_d = FS_REQ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FS_ERR: begin
                valid_d = 1'b0;
            end
            default: state_d = FS_IDLE;
        endcase
        if ((state_q == FS_REQ || state_q == FS_DRAIN) && !imem_ack
                && cnt_d == CW'(TIMEOUT_CYCLES)) begin
            state_d = FS_ERR;
            err_d   = 1'b1;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FS_IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            instr_q      <= NOP_WORD;
            pc4_q        <= 32'h0;
            valid_q      <= 1'b0;
            skid_instr_q <= NOP_WORD;
            skid_pc4_q   <= 32'h0;
            cnt_q        <= '0;
            misalign_q   <= 1'b0;
            err_q        <= 1'b0;
`ifdef IF_DELAY_SLOT_EN
            pend_q       <= 1'b0;
            pend_tgt_q   <= 32'h0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            cnt_q        <= cnt_d;
            misalign_q   <= misalign_d;
            err_q        <= err_d;
`ifdef IF_DELAY_SLOT_EN
            pend_q       <= pend_d;
            pend_tgt_q   <= pend_tgt_d;
`endif
        end
    end

    assign if_id_instr    = instr_q;
    assign if_id_pc4      = pc4_q;
    assign if_id_valid    = valid_q;
    assign fetch_misalign = misalign_q;
    assign fetch_err      = err_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

    logic        clk, rst;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall;
    logic [1:0]  pcsource;
    logic [31:0] rs_data;
    logic [31:0] if_id_instr, if_id_pc4;
    logic        if_id_valid, fetch_misalign, fetch_err;

    int checks = 0;
    int failures = 0;
    int ack_lat = 0;
    int wait_cnt = 0;
    bit ack_en = 1'b1;
    int n;

    if_fetch_stage #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_ack       (imem_ack),
        .stall          (stall),
        .pcsource       (pcsource),
        .rs_data        (rs_data),
        .if_id_instr    (if_id_instr),
        .if_id_pc4      (if_id_pc4),
        .if_id_valid    (if_id_valid),
        .fetch_misalign (fetch_misalign),
        .fetch_err      (fetch_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // mem[k] = k, except a j 0x100 at 0x14 and a beq -4 at 0x100
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h14)  return 32'h0800_0040;
        if (a == 32'h100) return 32'h1000_FFFC;
        return a >> 2;
    endfunction

    // Memory responder: decides the ack for the next edge shortly after each rising edge.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (imem_req && ack_en) begin
                if (wait_cnt >= ack_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    wait_cnt   = 0;
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; pcsource = 2'b00; rs_data = 32'h0;
        step(); step();
        check("rst_req",   {31'h0, imem_req}, 32'd0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_instr", if_id_instr, 32'h0);
        check("rst_pc4",   if_id_pc4, 32'h0);
        check("rst_valid", {31'h0, if_id_valid}, 32'd0);
        check("rst_mis",   {31'h0, fetch_misalign}, 32'd0);
        check("rst_err",   {31'h0, fetch_err}, 32'd0);
        rst = 1'b0;

        // zero-wait streaming
        step();
        check("zw_req0",  {31'h0, imem_req}, 32'd1);
        check("zw_addr0", imem_addr, 32'h0);
        step();
        check("zw_addr1", imem_addr, 32'h4);
        check("zw_ins0",  if_id_instr, 32'h0);
        check("zw_pc4_0", if_id_pc4, 32'h4);
        check("zw_val0",  {31'h0, if_id_valid}, 32'd1);
        step();
        check("zw_addr2", imem_addr, 32'h8);
        check("zw_ins1",  if_id_instr, 32'h1);
        check("zw_pc4_1", if_id_pc4, 32'h8);
        step();
        check("zw_addr3", imem_addr, 32'hC);
        check("zw_ins2",  if_id_instr, 32'h2);
        check("zw_pc4_2", if_id_pc4, 32'hC);

        // slow ack arriving while stalled -> skid
        ack_lat = 3;
        step();
        check("sk_addr", imem_addr, 32'h10);
        check("sk_ins3", if_id_instr, 32'h3);
        stall = 1'b1;
        step();
        check("sk_hold_ins", if_id_instr, 32'h3);
        check("sk_hold_val", {31'h0, if_id_valid}, 32'd1);
        step(); step();
        check("sk_req_wait", {31'h0, imem_req}, 32'd1);
        step();
        check("sk_req_off",  {31'h0, imem_req}, 32'd0);
        check("sk_held_ins", if_id_instr, 32'h3);
        stall = 1'b0;
        step();
        check("sk_out_ins", if_id_instr, 32'h4);
        check("sk_out_pc4", if_id_pc4, 32'h14);
        check("sk_out_val", {31'h0, if_id_valid}, 32'd1);
        check("sk_next_addr", imem_addr, 32'h14);
        ack_lat = 0;
        step();
        check("sk_bubble", {31'h0, if_id_valid}, 32'd0);
        step();
        check("j_ins", if_id_instr, 32'h0800_0040);
        check("j_pc4", if_id_pc4, 32'h18);

        // j 0x100 with the 0x18 word acked the same cycle
        pcsource = 2'b11;
        step();
        check("j_addr",   imem_addr, 32'h100);
        check("j_bubble", {31'h0, if_id_valid}, 32'd0);
        pcsource = 2'b00;
        step();
        check("beq_ins", if_id_instr, 32'h1000_FFFC);
        check("beq_pc4", if_id_pc4, 32'h104);
        pcsource = 2'b10;
        step();
        check("beq_addr",   imem_addr, 32'hF4);
        check("beq_bubble", {31'h0, if_id_valid}, 32'd0);
        pcsource = 2'b00;
        step();
        check("beq_tgt_ins", if_id_instr, 32'h3D);
        check("beq_tgt_pc4", if_id_pc4, 32'hF8);

        // jr to a misaligned register value
        pcsource = 2'b01; rs_data = 32'h0000_2003;
        step();
        check("jr_addr", imem_addr, 32'h2000);
        check("jr_mis",  {31'h0, fetch_misalign}, 32'd1);
        pcsource = 2'b00;
        step();
        check("jr_mis_off", {31'h0, fetch_misalign}, 32'd0);
        check("jr_ins",     if_id_instr, 32'h800);

        // redirect while a request is outstanding -> drain
        ack_lat = 2;
        step();
        check("dr_ins",  if_id_instr, 32'h801);
        check("dr_addr", imem_addr, 32'h2008);
        pcsource = 2'b01; rs_data = 32'h0000_3000;
        step();
        check("dr_hold_addr", imem_addr, 32'h2008);
        check("dr_req",       {31'h0, imem_req}, 32'd1);
        check("dr_bubble",    {31'h0, if_id_valid}, 32'd0);
        check("dr_no_mis",    {31'h0, fetch_misalign}, 32'd0);
        pcsource = 2'b00;
        step(); step();
        check("dr_new_addr", imem_addr, 32'h3000);
        check("dr_discard",  {31'h0, if_id_valid}, 32'd0);
        ack_lat = 0;
        step(); step();
        check("dr_tgt_ins", if_id_instr, 32'hC00);
        check("dr_tgt_pc4", if_id_pc4, 32'h3004);

        // bus timeout
        ack_en = 1'b0;
        step();
        check("to_addr", imem_addr, 32'h3008);
        n = 0;
        while (!fetch_err && n < 40) begin
            step();
            n++;
        end
        check("to_cycles", n, 32'd16);
        check("to_err",    {31'h0, fetch_err}, 32'd1);
        check("to_req",    {31'h0, imem_req}, 32'd0);
        check("to_valid",  {31'h0, if_id_valid}, 32'd0);
        step();
        check("to_sticky", {31'h0, fetch_err}, 32'd1);

        // recovery through reset
        rst = 1'b1;
        step();
        check("rr_err",  {31'h0, fetch_err}, 32'd0);
        check("rr_addr", imem_addr, 32'h0);
        check("rr_req",  {31'h0, imem_req}, 32'd0);
        rst = 1'b0; ack_en = 1'b1;
        step();
        check("rr_req1", {31'h0, imem_req}, 32'd1);
        step();
        check("rr_addr1", imem_addr, 32'h4);
        check("rr_valid", {31'h0, if_id_valid}, 32'd1);
        check("rr_ins",   if_id_instr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
